// File: rtl/pwm_audio_dac.sv
// Multi-channel PWM audio DAC.
// Signed samples arrive over valid/ready. Each sample gets a volume shift with saturation and is
// converted to an offset-binary duty. Duties are double-buffered and swapped in only on PWM
// period boundaries.
// Optional build macro: SIGMA_DELTA_EN adds first-order noise shaping of the truncation error.
module pwm_audio_dac #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PWM_WIDTH = 8,
    parameter int unsigned VOL_MAX   = 7
) (
    input  logic                      clock,
    input  logic                      clock_sreset,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [3:0]                volume_shift,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      underrun,
    output logic                      clipped
);
    localparam int unsigned ExtW = WIDTH + VOL_MAX;
    localparam int unsigned ResW = WIDTH - PWM_WIDTH;
    localparam logic [PWM_WIDTH-1:0] DutyMid = {1'b1, {(PWM_WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     SatMax  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     SatMin  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [PWM_WIDTH-1:0]               cnt_q, cnt_d;
    logic                               pend_valid_q, pend_valid_d;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0] active_q, active_d;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0][PWM_WIDTH-1:0] conv_duty;
    logic [CHANNELS-1:0]                pwm_q, pwm_d;
    logic                               underrun_q, underrun_d;
    logic                               clipped_q, clipped_d;
    logic                               wrap, accept;
    logic [3:0]                         shamt;

    logic signed [ExtW-1:0] ext [CHANNELS];
    logic [WIDTH-1:0]       sat [CHANNELS];
    logic [CHANNELS-1:0]    clip;

`ifdef SIGMA_DELTA_EN
    logic [CHANNELS-1:0][ResW-1:0] resid_q, resid_d;
    logic [WIDTH:0]                sum [CHANNELS];
    logic [WIDTH-1:0]              shaped [CHANNELS];
`else
    logic                          unused_sat_lsbs;
`endif

    // Per-channel volume shift, saturation and conversion to offset-binary duty.
    always_comb begin
        shamt = (volume_shift > 4'(VOL_MAX)) ? 4'(VOL_MAX) : volume_shift;
`ifndef SIGMA_DELTA_EN
        unused_sat_lsbs = 1'b0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            ext[c] = ExtW'($signed(data_in[c*WIDTH +: WIDTH])) <<< shamt;
            // In range only if every bit from the result sign down to bit WIDTH-1 agrees.
            clip[c] = ~((&ext[c][ExtW-1:WIDTH-1]) | ~(|ext[c][ExtW-1:WIDTH-1]));
            sat[c]  = clip[c] ? (ext[c][ExtW-1] ? SatMin : SatMax) : ext[c][WIDTH-1:0];
`ifdef SIGMA_DELTA_EN
            // Residual is non-negative, so only positive overflow is possible.
            sum[c]       = {sat[c][WIDTH-1], sat[c]} + (WIDTH+1)'(resid_q[c]);
            shaped[c]    = (sum[c][WIDTH] != sum[c][WIDTH-1]) ? SatMax : sum[c][WIDTH-1:0];
            conv_duty[c] = shaped[c][WIDTH-1 -: PWM_WIDTH] ^ DutyMid;
            resid_d[c]   = accept ? shaped[c][ResW-1:0] : resid_q[c];
`else
            conv_duty[c]    = sat[c][WIDTH-1 -: PWM_WIDTH] ^ DutyMid;
            unused_sat_lsbs = unused_sat_lsbs ^ (^sat[c][ResW-1:0]);
`endif
        end
    end

    // Handshake, double-buffer control and PWM compare.
    always_comb begin
        wrap         = &cnt_q;
        data_ready   = ~pend_valid_q | wrap;
        accept       = data_valid & data_ready;
        cnt_d        = cnt_q + 1'b1;
        active_d     = (wrap && pend_valid_q) ? pend_q : active_q;
        pend_d       = accept ? conv_duty : pend_q;
        // A sample accepted on the wrap cycle refills the buffer just emptied.
        pend_valid_d = accept | (pend_valid_q & ~wrap);
        underrun_d   = wrap & ~pend_valid_q;
        clipped_d    = accept & (|clip);
        for (int c = 0; c < CHANNELS; c++) begin
            pwm_d[c] = cnt_q < active_q[c];
        end
    end

    // State registers; reset restores mid-scale silence and discards any partial period.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            active_q     <= {CHANNELS{DutyMid}};
            pend_q       <= {CHANNELS{DutyMid}};
            pwm_q        <= '0;
            underrun_q   <= 1'b0;
            clipped_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pwm_q        <= pwm_d;
            underrun_q   <= underrun_d;
            clipped_q    <= clipped_d;
        end
    end

`ifdef SIGMA_DELTA_EN
    // Noise-shaping residuals, updated once per accepted sample.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            resid_q <= '0;
        end else begin
            resid_q <= resid_d;
        end
    end
`endif

    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;
    assign clipped  = clipped_q;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Self-checking bench for pwm_audio_dac (CHANNELS=2, WIDTH=16, PWM_WIDTH=8, VOL_MAX=7).
// Accepted samples are converted by a reference model and queued; at each period boundary the
// queued duty becomes the expected active duty, compared against the measured high count.
module tb_pwm_audio_dac;
    logic        clock = 1'b0;
    logic        clock_sreset = 1'b1;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data_in = '0;
    logic [3:0]  volume_shift = '0;
    logic [1:0]  pwm_out;
    logic        underrun;
    logic        clipped;

    pwm_audio_dac #(
        .CHANNELS (2),
        .WIDTH    (16),
        .PWM_WIDTH(8),
        .VOL_MAX  (7)
    ) dut (
        .clock       (clock),
        .clock_sreset(clock_sreset),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_in     (data_in),
        .volume_shift(volume_shift),
        .pwm_out     (pwm_out),
        .underrun    (underrun),
        .clipped     (clipped)
    );

    always #5 clock = ~clock;

    typedef logic [1:0][7:0] duty_pair_t;

    int         n_tests = 0;
    int         n_fail = 0;
    duty_pair_t sb_q[$];
    duty_pair_t m_act = {8'd128, 8'd128};
    int         m_cnt = 0;
    int         m_r[2] = '{0, 0};
    int         hi[2] = '{0, 0};
    int         last_hi[2] = '{0, 0};
    int         und_count = 0;
    int         clip_count = 0;
    int         period_count = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference conversion: shift, saturate, optional residual add, offset-binary top byte.
    function automatic int conv(input logic [15:0] smp, input int vol, inout int r,
                                output bit clip);
        longint v;
        v = longint'($signed(smp));
        v = v * (longint'(1) << ((vol > 7) ? 7 : vol));
        clip = (v > 32767) || (v < -32768);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`ifdef SIGMA_DELTA_EN
        v = v + r;
        if (v > 32767) v = 32767;
        r = int'(v & 255);
`else
        r = 0;
`endif
        return int'(((v >>> 8) & 255) ^ 128);
    endfunction

    // One clock: predict, advance the model at the edge, check outputs 1 time unit later.
    task automatic cycle(input logic rst);
        bit         acc;
        bit         wrap;
        bit         exp_und;
        bit         exp_clip;
        bit         clip;
        int         old_cnt;
        duty_pair_t old_act;
        duty_pair_t nd;
        clock_sreset = rst;
        acc = 1'b0;
        if (!rst) begin
            check_eq("data_ready", int'(data_ready), int'(sb_q.size() == 0 || m_cnt == 255));
            acc = data_valid && (sb_q.size() == 0 || m_cnt == 255);
        end
        @(posedge clock);
        old_cnt = m_cnt;
        old_act = m_act;
        if (rst) begin
            m_cnt = 0;
            m_act = {8'd128, 8'd128};
            sb_q.delete();
            m_r = '{0, 0};
            hi = '{0, 0};
            #1;
            check_eq("rst_pwm", int'(pwm_out), 0);
            check_eq("rst_underrun", int'(underrun), 0);
            check_eq("rst_clipped", int'(clipped), 0);
            check_eq("rst_ready", int'(data_ready), 1);
        end else begin
            wrap = (m_cnt == 255);
            exp_und = wrap && (sb_q.size() == 0);
            if (wrap && sb_q.size() != 0) m_act = sb_q.pop_front();
            exp_clip = 1'b0;
            if (acc) begin
                for (int c = 0; c < 2; c++) begin
                    nd[c] = 8'(conv(data_in[c*16 +: 16], int'(volume_shift), m_r[c], clip));
                    exp_clip |= clip;
                end
                sb_q.push_back(nd);
            end
            m_cnt = (m_cnt + 1) % 256;
            #1;
            check_eq("underrun", int'(underrun), int'(exp_und));
            check_eq("clipped", int'(clipped), int'(exp_clip));
            und_count += int'(underrun);
            clip_count += int'(clipped);
            for (int c = 0; c < 2; c++) hi[c] += int'(pwm_out[c]);
            if (old_cnt == 255) begin
                for (int c = 0; c < 2; c++) begin
                    check_eq($sformatf("period_ch%0d", c), hi[c], int'(old_act[c]));
                end
                last_hi = hi;
                hi = '{0, 0};
                period_count++;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic wait_periods(input int n);
        int target;
        target = period_count + n;
        for (int i = 0; i < 256 * (n + 1) && period_count < target; i++) cycle(1'b0);
    endtask

    // Present a sample and hold it until the block accepts it.
    task automatic send(input logic [15:0] s0, input logic [15:0] s1, input logic [3:0] vol);
        bit done;
        done = 1'b0;
        data_valid = 1'b1;
        data_in = {s1, s0};
        volume_shift = vol;
        for (int i = 0; i < 600 && !done; i++) begin
            done = (sb_q.size() == 0 || m_cnt == 255);
            cycle(1'b0);
        end
        check_eq("send_accepted", int'(done), 1);
        data_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        cycle(1'b1);
        cycle(1'b1);

        // Idle after reset: mid-scale duty, one underrun per period.
        und_count = 0;
        run_cycles(512);
        check_eq("idle_underruns", und_count, 2);
        check_eq("idle_hi_ch0", last_hi[0], 128);

        // Full-scale positive and negative, no volume.
        clip_count = 0;
        run_cycles(50);
        send(16'h7FFF, 16'h8000, 4'd0);
        wait_periods(2);
        check_eq("fs_hi_ch0", last_hi[0], 255);
        check_eq("fs_hi_ch1", last_hi[1], 0);
        check_eq("fs_no_clip", clip_count, 0);

        // Volume shift with clipping, then an in-range shift.
        run_cycles(30);
        clip_count = 0;
        send(16'h4000, 16'h0000, 4'd2);
        wait_periods(2);
        check_eq("vol_clip_count", clip_count, 1);
        check_eq("vol_clip_hi_ch0", last_hi[0], 255);
        send(16'h0100, 16'h0000, 4'd2);
        wait_periods(2);
        check_eq("vol_hi_ch0", last_hi[0], 132);

        // Back-to-back valid mid-period: second waits for the wrap.
        run_cycles(40);
        send(16'h3000, 16'h0000, 4'd0);
        send(16'hD000, 16'h0000, 4'd0);
        wait_periods(1);
        check_eq("b2b_first_ch0", last_hi[0], 176);
        wait_periods(1);
        check_eq("b2b_second_ch0", last_hi[0], 80);

        // Reset at counter 60 with duty 200 active.
        send(16'h4800, 16'h4800, 4'd0);
        wait_periods(1);
        run_cycles(60);
        cycle(1'b1);
        wait_periods(1);
        check_eq("post_rst_hi_ch0", last_hi[0], 128);
        check_eq("post_rst_hi_ch1", last_hi[1], 128);

        // Constant small sample, one accept per period.
        for (int i = 0; i < 5; i++) begin
            send(16'h0080, 16'h0080, 4'd0);
            wait_periods(1);
`ifdef SIGMA_DELTA_EN
            if (i > 0) check_eq("sd_hi_ch0", last_hi[0], ((i - 1) % 2 == 1) ? 129 : 128);
`else
            if (i > 0) check_eq("trunc_hi_ch0", last_hi[0], 128);
`endif
        end
        wait_periods(1);

        // Random samples, volumes (including values above VOL_MAX) and gaps.
        for (int i = 0; i < 6; i++) begin
            run_cycles($urandom_range(0, 300));
            send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        end
        wait_periods(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
